sync_ram_responder: RTL and testbench
=====================================

Name: sync_ram_responder

Overview:
- Memory-side responder for the CPU's byte-wide MAR / data / cs / we / oe bus.
- Holds a 2^ADDR_WIDTH x DATA_WIDTH array and serves one read or write at a time.
- Inserts a programmable number of wait states and pulses a ready completion handshake.
- Enforces an optional write-protected low region and keeps saturating access counters for bench visibility.

Parameters:
- DATA_WIDTH, 8: width of the data bus and of each memory word.
- ADDR_WIDTH, 8: address width; the array depth is 2^ADDR_WIDTH (256 bytes at default).
- WAIT_STATES, 1: extra cycles per access; legal range 0..7.
- PROT_LIMIT, 8'h00: addresses strictly below this value are write-protected while wp=1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  ADDR_WIDTH  access address, driven from MAR.
- data  inout  DATA_WIDTH  bidirectional bus; master drives it on writes, this block drives it on reads.
- cs_input  input  1  chip select.
- we  input  1  write enable.
- oe  input  1  output enable (read request).
- wp  input  1  enables write protection below PROT_LIMIT.
- ready  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse.
- rd_count  output  16  completed reads, saturating.
- wr_count  output  16  committed writes, saturating.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; ready=0; err=0; rd_valid=0; data bus released (Z); rd_count=0; wr_count=0.
  - A write pending in WAIT is aborted and not committed.
  - Memory contents are NOT cleared.
- Request decode, sampled at a rising edge in IDLE:
  - Write: cs_input=1, we=1, oe=0.
  - Read: cs_input=1, we=0, oe=1.
  - cs_input=0, or we=0 with oe=0: no request.
  - Illegal: cs_input=1, we=1, oe=1. err pulses the next cycle; no access; no ready; state stays IDLE.
- Accept (edge E):
  - Latch addr, op, and data (write) into internal registers.
  - Load wait counter with WAIT_STATES; clear rd_valid.
  - Inputs are ignored until completion.
- State machine:
  - IDLE -> WAIT when WAIT_STATES>0; counter decrements each edge; complete when the counter reaches 0.
  - IDLE -> DONE directly when WAIT_STATES=0.
  - Completion occurs at edge E+WAIT_STATES.
  - ready=1 for exactly the cycle following the completion edge, then the state returns to IDLE.
  - The next request can be sampled at edge E+WAIT_STATES+1. Back-to-back accesses therefore take WAIT_STATES+1 cycles each.
- Write completion:
  - If wp=1 and latched addr < PROT_LIMIT: memory is unchanged, wr_count does not change, and err pulses alongside ready.
  - wp is sampled at the completion edge.
  - Otherwise mem[addr] <= latched data and wr_count increments.
- Read completion:
  - rdata <= mem[latched addr]; rd_valid=1; rd_count increments.
- Bus drive:
  - data = rdata when rd_valid=1, cs_input=1, oe=1 and we=0; otherwise Z.
  - rd_valid holds after ready so the master may sample late.
  - rd_valid clears on any new accepted request, on cs_input=0, on oe=0, or on reset.
- Read-after-write to the same address returns the new value, because the write commits before the read is accepted.
- Counters stop at 16'hFFFF; no wrap.
- Address space is full-decode; no aliasing, no out-of-range case.

Test Plan:
- Write then read, WAIT_STATES=1: write 8'h1C to 8'h01 at edge E; ready high in cycle E+2; read 8'h01 returns 8'h1C on data after ready; wr_count=1, rd_count=1.
- WAIT_STATES=0 streaming: write bytes 8'h10, 8'h1C, 8'h30 to 8'h00..8'h02 on consecutive accepts; ready pulses every cycle; readback matches; wr_count=3.
- Write protect, PROT_LIMIT=8'h04, wp=1: write 8'hAA to 8'h02 -> ready and err pulse together, mem[8'h02] keeps its old value, wr_count unchanged. Same write with wp=0 -> commits.
- Illegal select, cs_input=1, we=1, oe=1: err pulse only; no ready; memory and counts unchanged; data stays Z.
- Reset mid-write, WAIT_STATES=3: assert rst during WAIT -> write to 8'h20 is not committed; ready=0 and data=Z immediately; counters=0; previously written 8'h1D location still reads its value after reset.
- Bus release: after a read completes, drop oe -> data goes Z the same cycle. Re-raise oe without a new request -> data stays Z, because rd_valid is cleared.

Source files
------------

// File: rtl/sync_ram_responder.sv
// Memory-side responder for the CPU byte bus: serves one access at a time with
// programmable wait states, a write-protected low window and saturating counters.
module sync_ram_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] PROT_LIMIT = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs_input,
    input  logic                  we,
    input  logic                  oe,
    input  logic                  wp,
    output logic                  ready,
    output logic                  err,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state, state_next;
    logic [2:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] lat_addr, cur_addr;
    logic [DATA_WIDTH-1:0] lat_data, cur_data, rdata;
    logic                  lat_wr, cur_wr;
    logic                  rd_valid;
    logic                  req_wr, req_rd, req_bad, accept;
    logic                  complete, protect, do_write, do_read, prot_err;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    assign req_wr  = cs_input & we & ~oe;
    assign req_rd  = cs_input & ~we & oe;
    assign req_bad = cs_input & we & oe;
    assign accept  = (state == IDLE) & (req_wr | req_rd);

    // With no wait states the access completes on its accept edge, so the live bus feeds the datapath
    assign cur_addr = (state == IDLE) ? addr : lat_addr;
    assign cur_data = (state == IDLE) ? data : lat_data;
    assign cur_wr   = (state == IDLE) ? we   : lat_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && (WAIT_STATES != 0)) state_next = WAIT;
            WAIT:    if (wait_cnt == 3'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        complete = 1'b0;
        case (state)
            IDLE:    complete = accept && (WAIT_STATES == 0);
            WAIT:    complete = (wait_cnt == 3'd1);
            default: complete = 1'b0;
        endcase
        protect  = wp && (cur_addr < PROT_LIMIT);
        do_write = complete && cur_wr && !protect;
        prot_err = complete && cur_wr && protect;
        do_read  = complete && !cur_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            ready <= complete;
            err   <= prot_err | ((state == IDLE) & req_bad);
            if (accept)              wait_cnt <= WAIT_INIT;
            else if (state == WAIT)  wait_cnt <= wait_cnt - 3'd1;
            // Read data stays on offer until the master deselects or starts another access
            if (do_read)                          rd_valid <= 1'b1;
            else if (accept || !cs_input || !oe)  rd_valid <= 1'b0;
            if (do_read && (rd_count != 16'hFFFF))  rd_count <= rd_count + 16'd1;
            if (do_write && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr <= addr;
            lat_data <= data;
            lat_wr   <= we;
        end
        if (do_write) mem[cur_addr] <= cur_data;
        if (do_read)  rdata <= mem[cur_addr];
    end

    assign data = (rd_valid && cs_input && oe && !we) ? rdata : 'z;

endmodule

// File: tb/tb_sync_ram_responder.sv
// Bench for sync_ram_responder: three instances (1, 0 and 3 wait states) checked
// against a transaction-level memory model with directed and random accesses.
module tb_sync_ram_responder;
    localparam int NK = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        we, oe, wp;
    logic [2:0]  cs;
    logic [2:0]  drv;
    logic [7:0]  tb_data;
    tri1  [7:0]  bus0, bus1, bus2;
    logic [2:0]  ready, err;
    logic [15:0] rdc0, rdc1, rdc2, wrc0, wrc1, wrc2;

    int n_vec = 0;
    int n_err = 0;
    int cur_k = 0;

    logic [7:0] mmem  [NK][256];
    bit         known [NK][256];
    int         mrd   [NK];
    int         mwr   [NK];

    always #5 clk = ~clk;

    assign bus0 = drv[0] ? tb_data : 'z;
    assign bus1 = drv[1] ? tb_data : 'z;
    assign bus2 = drv[2] ? tb_data : 'z;

    sync_ram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(1), .PROT_LIMIT(8'h04)) u0 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus0), .cs_input(cs[0]), .we(we), .oe(oe),
        .wp(wp), .ready(ready[0]), .err(err[0]), .rd_count(rdc0), .wr_count(wrc0));
    sync_ram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0), .PROT_LIMIT(8'h04)) u1 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus1), .cs_input(cs[1]), .we(we), .oe(oe),
        .wp(wp), .ready(ready[1]), .err(err[1]), .rd_count(rdc1), .wr_count(wrc1));
    sync_ram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(3), .PROT_LIMIT(8'h04)) u2 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus2), .cs_input(cs[2]), .we(we), .oe(oe),
        .wp(wp), .ready(ready[2]), .err(err[2]), .rd_count(rdc2), .wr_count(wrc2));

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [7:0] get_bus(input int k);
        case (k)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    function automatic logic [15:0] get_rdc(input int k);
        case (k)
            0:       return rdc0;
            1:       return rdc1;
            default: return rdc2;
        endcase
    endfunction

    function automatic logic [15:0] get_wrc(input int k);
        case (k)
            0:       return wrc0;
            1:       return wrc1;
            default: return wrc2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, cur_k, $time, got, exp);
        end
    endtask

    task automatic check_counts(input int k);
        chk("rd_count", {16'h0, get_rdc(k)}, mrd[k]);
        chk("wr_count", {16'h0, get_wrc(k)}, mwr[k]);
    endtask

    task automatic release_bus();
        cs  = '0;
        we  = 1'b0;
        oe  = 1'b0;
        drv = '0;
        addr = 8'($urandom);
    endtask

    task automatic idle_cycle();
        release_bus();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called and returning at a falling edge; leaves the request asserted for streaming.
    // wpm: 0/1 force wp, 2 random (re-drawn just before the completion edge).
    task automatic access(input int k, input bit is_wr, input logic [7:0] a,
                          input logic [7:0] d, input int wpm);
        int w;
        bit prot;
        w = ws_of(k);
        cur_k = k;
        addr = a;
        we = is_wr;
        oe = !is_wr;
        cs = '0;
        cs[k] = 1'b1;
        drv = '0;
        drv[k] = is_wr;
        tb_data = d;
        wp = (wpm == 2) ? 1'($urandom_range(0, 1)) : 1'(wpm);
        @(posedge clk);
        for (int n = 0; n < w; n++) begin
            @(negedge clk);
            chk("ready_during_wait", ready[k], 0);
            if (!is_wr) chk("bus_z_during_wait", get_bus(k), 8'hFF);
            addr = 8'($urandom);
            if (is_wr) tb_data = 8'($urandom);
            if (n == w - 1 && wpm == 2) wp = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        @(negedge clk);
        prot = is_wr && wp && (a < 8'h04);
        if (is_wr) begin
            if (!prot) begin
                mmem[k][a] = d;
                known[k][a] = 1'b1;
                if (mwr[k] < 65535) mwr[k]++;
            end
        end else if (mrd[k] < 65535) begin
            mrd[k]++;
        end
        chk("ready", ready[k], 1);
        chk("err_at_done", err[k], prot);
        if (!is_wr && known[k][a]) chk("read_data", get_bus(k), mmem[k][a]);
        check_counts(k);
    endtask

    task automatic illegal(input int k);
        cur_k = k;
        addr = 8'($urandom);
        cs = '0;
        cs[k] = 1'b1;
        we = 1'b1;
        oe = 1'b1;
        drv = '0;
        @(posedge clk);
        @(negedge clk);
        chk("illegal_err", err[k], 1);
        chk("illegal_no_ready", ready[k], 0);
        chk("illegal_bus_z", get_bus(k), 8'hFF);
        release_bus();
        @(posedge clk);
        @(negedge clk);
        chk("illegal_err_clears", err[k], 0);
        chk("illegal_no_late_ready", ready[k], 0);
        check_counts(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b1;
        tb_data = '0;
        wp = 1'b0;
        release_bus();
        for (int k = 0; k < NK; k++) begin
            mrd[k] = 0;
            mwr[k] = 0;
            for (int i = 0; i < 256; i++) known[k][i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            cur_k = k;
            chk("reset_ready", ready[k], 0);
            chk("reset_err", err[k], 0);
            chk("reset_bus_z", get_bus(k), 8'hFF);
            check_counts(k);
        end
        rst = 1'b0;
        @(negedge clk);

        // One wait state: write then read back, then bus release behaviour
        access(0, 1'b1, 8'h01, 8'h1C, 0);
        idle_cycle();
        access(0, 1'b0, 8'h01, 8'h00, 0);
        chk("rd_01_value", get_bus(0), 8'h1C);
        oe = 1'b0;
        #1 chk("bus_z_after_oe_drop", get_bus(0), 8'hFF);
        @(posedge clk);
        @(negedge clk);
        oe = 1'b1;
        #1 chk("bus_z_after_oe_reraise", get_bus(0), 8'hFF);
        cs = '0;
        oe = 1'b0;
        idle_cycle();

        // Write protection below 0x04
        access(0, 1'b1, 8'h02, 8'h55, 0);
        idle_cycle();
        access(0, 1'b1, 8'h02, 8'hAA, 1);
        idle_cycle();
        access(0, 1'b0, 8'h02, 8'h00, 0);
        chk("protected_keeps_old", get_bus(0), 8'h55);
        idle_cycle();
        access(0, 1'b1, 8'h02, 8'hAA, 0);
        idle_cycle();
        access(0, 1'b0, 8'h02, 8'h00, 1);
        chk("unprotected_commits", get_bus(0), 8'hAA);
        idle_cycle();
        illegal(0);

        // Zero wait states: back-to-back streaming
        access(1, 1'b1, 8'h00, 8'h10, 0);
        access(1, 1'b1, 8'h01, 8'h1C, 0);
        access(1, 1'b1, 8'h02, 8'h30, 0);
        access(1, 1'b0, 8'h00, 8'h00, 0);
        access(1, 1'b0, 8'h01, 8'h00, 0);
        access(1, 1'b0, 8'h02, 8'h00, 0);
        chk("stream_wr_count", {16'h0, wrc1}, 3);
        idle_cycle();
        illegal(1);

        // Three wait states: reset during a pending write
        access(2, 1'b1, 8'h1D, 8'h77, 0);
        idle_cycle();
        access(2, 1'b1, 8'h20, 8'h33, 0);
        idle_cycle();
        cur_k = 2;
        addr = 8'h20;
        cs = 3'b100;
        we = 1'b1;
        oe = 1'b0;
        wp = 1'b0;
        drv = 3'b100;
        tb_data = 8'hC4;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drv = '0;
        #1;
        for (int k = 0; k < NK; k++) begin
            mrd[k] = 0;
            mwr[k] = 0;
        end
        chk("rst_mid_ready", ready[2], 0);
        chk("rst_mid_bus_z", get_bus(2), 8'hFF);
        check_counts(2);
        release_bus();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_no_ready", ready[2], 0);
        access(2, 1'b0, 8'h20, 8'h00, 0);
        chk("aborted_write_absent", get_bus(2), 8'h33);
        idle_cycle();
        access(2, 1'b0, 8'h1D, 8'h00, 0);
        chk("survives_reset", get_bus(2), 8'h77);
        idle_cycle();

        // Randomized traffic per instance
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 19);
                if (r == 0)
                    illegal(k);
                else if (r < 10)
                    access(k, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 254)), 2);
                else
                    access(k, 1'b0, 8'($urandom_range(0, 15)), 8'h00, 2);
                if ($urandom_range(0, 1) == 1) idle_cycle();
            end
            idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
